mcode_fetch: RTL and testbench

- Microinstruction store and pipeline register on the consumer side of the microprogram sequencer.
- On each sequencer step it takes the sequencer's microaddress (PC) and returns the next microword's fields to the sequencer: opc, condition bit x, DIRB and DIRI.
- Owns the microcode RAM (written by a loader port), a 2-flop condition synchronizer, and a loop counter used as a branch condition.
- Runs on the fast system clock; sequencer steps are marked by a one-cycle enable strobe.

---
 rtl/mcode_pkg.sv | 46 ++++
 rtl/mcode_fetch_if.sv | 42 ++++
 rtl/cond_sync.sv | 32 +++
 rtl/mcode_fetch.sv | 124 ++++++++++++
 tb/tb_mcode_fetch.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mcode_pkg.sv
// Shared definitions for the microcode fetch block.
//
// Microword layout, MSB first:
//   opc[3] csel[2] DIRB[8] DIRI[8] ctrl[CW] ld_cnt dec_cnt halt
// The low control bits and ctrl sit at fixed positions. The fields above ctrl
// are given as offsets from the top of ctrl, i.e. bit CTRL_LSB + CW + <offset>.
package mcode_pkg;

    // Fixed low bits.
    localparam int unsigned HALT_BIT = 0;
    localparam int unsigned DEC_BIT  = 1;
    localparam int unsigned LD_BIT   = 2;
    localparam int unsigned CTRL_LSB = 3;

    // Offsets above the ctrl field.
    localparam int unsigned DIRI_LSB = 0;
    localparam int unsigned DIRI_MSB = 7;
    localparam int unsigned DIRB_LSB = 8;
    localparam int unsigned DIRB_MSB = 15;
    localparam int unsigned CSEL_LSB = 16;
    localparam int unsigned CSEL_MSB = 17;
    localparam int unsigned OPC_LSB  = 18;
    localparam int unsigned OPC_MSB  = 20;
    localparam int unsigned UPPER_W  = 21;

    // Condition select encodings.
    typedef enum logic [1:0] {
        CS_FALSE = 2'd0,
        CS_C0    = 2'd1,
        CS_C1    = 2'd2,
        CS_CNTZ  = 2'd3
    } csel_e;

    // Fetch state machine encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Total microword width for a given ctrl width.
    function automatic int unsigned word_width(input int unsigned cw);
        return CTRL_LSB + cw + UPPER_W;
    endfunction

endpackage

// File: rtl/mcode_fetch_if.sv
// Sequencer/loader bus of the microcode fetch block.
//
// Signals:
//   en, PC, go, cond     - step strobe, microaddress, start pulse, raw conditions
//   we, waddr, wdata     - microcode loader write port
//   opc, x, DIRB, DIRI,  - fetched microword fields and selected condition
//   ctrl, run            - datapath control field, RUN-state flag
// Modports: master = sequencer/loader side, slave = fetch block.
interface mcode_fetch_if
    import mcode_pkg::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned CW = 8
) ();

    localparam int unsigned MW = CTRL_LSB + CW + UPPER_W;

    logic          en;
    logic [AW-1:0] PC;
    logic          go;
    logic [1:0]    cond;
    logic          we;
    logic [AW-1:0] waddr;
    logic [MW-1:0] wdata;
    logic [2:0]    opc;
    logic          x;
    logic [7:0]    DIRB;
    logic [7:0]    DIRI;
    logic [CW-1:0] ctrl;
    logic          run;

    modport master (
        output en, PC, go, cond, we, waddr, wdata,
        input  opc, x, DIRB, DIRI, ctrl, run
    );

    modport slave (
        input  en, PC, go, cond, we, waddr, wdata,
        output opc, x, DIRB, DIRI, ctrl, run
    );

endinterface

// File: rtl/cond_sync.sv
// Two-flop synchronizer for asynchronous condition inputs.
//
// Ports:
//   ck    - clock, rising edge
//   rst_n - asynchronous active-low clear of both stages
//   d     - asynchronous input
//   q     - synchronized output, two ck edges behind d
module cond_sync #(
    parameter int unsigned W = 2
) (
    input  logic         ck,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync1_q;
    logic [W-1:0] sync2_q;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/mcode_fetch.sv
// Microcode store and instruction register feeding the microprogram sequencer.
//
// On each sequencer step (en strobe) while running, the microword at PC is
// loaded into the instruction register and its fields are returned to the
// sequencer. Also owns the condition synchronizer and a loop counter that can
// be tested as a branch condition.
//
// Ports:
//   ck    - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mcode_fetch_if.slave: en/PC/go/cond in, loader write port in,
//           opc/x/DIRB/DIRI/ctrl/run out
module mcode_fetch
    import mcode_pkg::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned CW = 8
) (
    input  logic         ck,
    input  logic         rst_n,
    mcode_fetch_if.slave bus
);

    localparam int unsigned MW    = word_width(CW);
    localparam int unsigned DEPTH = 1 << AW;
    // Base bit of the fields that sit above ctrl.
    localparam int unsigned UB    = CTRL_LSB + CW;

    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] rd_word;

    state_e        state_q, state_d;
    logic [MW-1:0] ir_q, ir_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    csync;
    logic          fetch;
    csel_e         csel;
    logic          x_c;

    // Microcode RAM: written by the loader in any state, never reset.
    always_ff @(posedge ck) begin
        if (bus.we) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    // Read happens before the same-edge write lands, so a colliding fetch
    // returns the old word.
    assign rd_word = mem[bus.PC];

    cond_sync #(
        .W(2)
    ) u_cond_sync (
        .ck   (ck),
        .rst_n(rst_n),
        .d    (bus.cond),
        .q    (csync)
    );

    assign fetch = (state_q == ST_RUN) && bus.en;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.go) state_d = ST_RUN;
            end
            ST_RUN: begin
                // The halting word is still loaded; the stop takes effect after it.
                if (bus.en && rd_word[HALT_BIT]) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (bus.go) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ir_d = fetch ? rd_word : ir_q;

    // Counter ops are driven by the word currently in IR, not the one being fetched.
    always_comb begin
        cnt_d = cnt_q;
        if (fetch) begin
            if (ir_q[LD_BIT]) begin
                cnt_d = ir_q[UB+DIRI_LSB +: 8];
            end else if (ir_q[DEC_BIT] && (cnt_q != 8'd0)) begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    assign csel = csel_e'(ir_q[UB+CSEL_LSB +: 2]);

    always_comb begin
        x_c = 1'b0;
        unique case (csel)
            CS_FALSE: x_c = 1'b0;
            CS_C0:    x_c = csync[0];
            CS_C1:    x_c = csync[1];
            CS_CNTZ:  x_c = (cnt_q == 8'd0);
        endcase
    end

    assign bus.opc  = ir_q[UB+OPC_LSB +: 3];
    assign bus.DIRB = ir_q[UB+DIRB_LSB +: 8];
    assign bus.DIRI = ir_q[UB+DIRI_LSB +: 8];
    assign bus.ctrl = ir_q[CTRL_LSB +: CW];
    assign bus.x    = x_c;
    assign bus.run  = (state_q == ST_RUN);

endmodule

// File: tb/tb_mcode_fetch.sv
// Directed bench for mcode_fetch: a behavioural model checked every cycle plus
// hand-computed literal expectations at key points.
module tb_mcode_fetch;

    logic ck    = 1'b0;
    logic rst_n = 1'b1;

    always #5 ck = ~ck;

    mcode_fetch_if #(.AW(8), .CW(8)) bus ();

    mcode_fetch #(
        .AW(8),
        .CW(8)
    ) dut (
        .ck   (ck),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Microword built straight from the documented field order.
    function automatic logic [31:0] mw(input logic [2:0] o, input logic [1:0] cs,
                                       input logic [7:0] b, input logic [7:0] i,
                                       input logic [7:0] c, input logic ld,
                                       input logic dec, input logic h);
        return {o, cs, b, i, c, ld, dec, h};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [256];
    logic [31:0] m_ir;
    logic [7:0]  m_cnt;
    bit          m_running, m_halted;
    logic [1:0]  m_s1, m_s2;

    always @(posedge ck or negedge rst_n) begin
        logic [31:0] old_ir;
        if (!rst_n) begin
            m_ir = '0; m_cnt = '0; m_running = 0; m_halted = 0;
            m_s1 = '0; m_s2 = '0;
        end else begin
            old_ir = m_ir;
            if (m_running && bus.en) begin
                m_ir = m_mem[bus.PC];
                if (old_ir[2]) m_cnt = old_ir[18:11];
                else if (old_ir[1] && m_cnt > 0) m_cnt = m_cnt - 1;
                if (m_ir[0]) begin m_running = 0; m_halted = 1; end
            end else if (!m_running && bus.go) begin
                m_running = 1; m_halted = 0;
            end
            if (bus.we) m_mem[bus.waddr] = bus.wdata;
            m_s2 = m_s1;
            m_s1 = bus.cond;
        end
    end

    function automatic logic model_x();
        case (m_ir[28:27])
            2'd0:    return 1'b0;
            2'd1:    return m_s2[0];
            2'd2:    return m_s2[1];
            default: return m_cnt == 0;
        endcase
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge ck) begin
        logic [31:0] exp_v, act_v;
        exp_v = {3'b0, m_ir[31:29], model_x(), m_ir[26:19], m_ir[18:11], m_ir[10:3],
                 m_running};
        act_v = {3'b0, bus.opc, bus.x, bus.DIRB, bus.DIRI, bus.ctrl, bus.run};
        check("model", act_v, exp_v);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge ck);
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] w);
        tick();
        bus.we = 1'b1; bus.waddr = a; bus.wdata = w;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a);
        tick();
        bus.PC = a; bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
    endtask

    task automatic pulse_go();
        tick();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 0; bus.PC = '0; bus.go = 0; bus.cond = 2'b00;
        bus.we = 0; bus.waddr = '0; bus.wdata = '0;
        #1 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        tick();
        check("rst_opc",  {29'b0, bus.opc}, 32'd0);
        check("rst_dirb", {24'b0, bus.DIRB}, 32'd0);
        check("rst_diri", {24'b0, bus.DIRI}, 32'd0);
        check("rst_ctrl", {24'b0, bus.ctrl}, 32'd0);
        check("rst_x",    {31'b0, bus.x}, 32'd0);
        check("rst_run",  {31'b0, bus.run}, 32'd0);

        load(8'h05, mw(3'd5, 2'd0, 8'h3C, 8'h11, 8'hA5, 0, 0, 0));
        load(8'h10, mw(3'd1, 2'd3, 8'h00, 8'h03, 8'h01, 1, 0, 0));
        load(8'h11, mw(3'd2, 2'd3, 8'h00, 8'h00, 8'h02, 0, 1, 0));
        load(8'h12, mw(3'd3, 2'd3, 8'h00, 8'h07, 8'h03, 1, 1, 0));
        load(8'h20, mw(3'd3, 2'd1, 8'h20, 8'h00, 8'h04, 0, 0, 0));
        load(8'h30, mw(3'd4, 2'd3, 8'h77, 8'h00, 8'h05, 0, 1, 1));
        load(8'h40, mw(3'd6, 2'd0, 8'h40, 8'h00, 8'h06, 0, 0, 0));

        // en while IDLE does nothing.
        fetch(8'h05);
        check("idle_en_opc", {29'b0, bus.opc}, 32'd0);
        check("idle_en_run", {31'b0, bus.run}, 32'd0);

        pulse_go();
        check("go_run", {31'b0, bus.run}, 32'd1);
        fetch(8'h05);
        check("fetch_opc",  {29'b0, bus.opc}, 32'd5);
        check("fetch_dirb", {24'b0, bus.DIRB}, 32'h3C);
        check("fetch_diri", {24'b0, bus.DIRI}, 32'h11);
        check("fetch_ctrl", {24'b0, bus.ctrl}, 32'hA5);
        check("fetch_run",  {31'b0, bus.run}, 32'd1);

        // Loop counter: load 3, then decrement to zero and saturate.
        fetch(8'h10);
        fetch(8'h11); check("loop_ld3",  {31'b0, bus.x}, 32'd0);
        fetch(8'h11); check("loop_dec1", {31'b0, bus.x}, 32'd0);
        fetch(8'h11); check("loop_dec2", {31'b0, bus.x}, 32'd0);
        fetch(8'h11); check("loop_dec3", {31'b0, bus.x}, 32'd1);
        fetch(8'h11); check("loop_sat",  {31'b0, bus.x}, 32'd1);
        fetch(8'h12); check("loop_pre",  {31'b0, bus.x}, 32'd1);
        fetch(8'h11); check("loop_ldpri", {31'b0, bus.x}, 32'd0);
        fetch(8'h11); check("loop_after", {31'b0, bus.x}, 32'd0);

        // Synchronizer latency on cond[0]; cond[1] must not matter.
        fetch(8'h20);
        check("sync_base", {31'b0, bus.x}, 32'd0);
        bus.cond = 2'b01;
        tick(); check("sync_1edge", {31'b0, bus.x}, 32'd0);
        tick(); check("sync_2edge", {31'b0, bus.x}, 32'd1);
        bus.cond = 2'b11;
        tick(); tick(); tick(); check("sync_c1_hi", {31'b0, bus.x}, 32'd1);
        bus.cond = 2'b01;
        tick(); tick(); check("sync_c1_lo", {31'b0, bus.x}, 32'd1);
        bus.cond = 2'b00;
        tick(); tick(); check("sync_fall", {31'b0, bus.x}, 32'd0);

        // Halt and resume.
        fetch(8'h30);
        check("halt_run",  {31'b0, bus.run}, 32'd0);
        check("halt_opc",  {29'b0, bus.opc}, 32'd4);
        check("halt_dirb", {24'b0, bus.DIRB}, 32'h77);
        for (int i = 0; i < 3; i++) begin
            fetch(8'h05);
            check("halt_hold", {29'b0, bus.opc}, 32'd4);
        end
        pulse_go();
        check("resume_run", {31'b0, bus.run}, 32'd1);
        fetch(8'h05);
        check("resume_opc", {29'b0, bus.opc}, 32'd5);

        // go and en together from HALT: transition only.
        fetch(8'h30);
        tick();
        bus.PC = 8'h05; bus.go = 1'b1; bus.en = 1'b1;
        tick();
        bus.go = 1'b0; bus.en = 1'b0;
        check("goen_run", {31'b0, bus.run}, 32'd1);
        check("goen_opc", {29'b0, bus.opc}, 32'd4);
        fetch(8'h05);
        check("goen_next", {29'b0, bus.opc}, 32'd5);

        // Write/fetch collision returns the old word.
        tick();
        bus.PC = 8'h40; bus.en = 1'b1;
        bus.we = 1'b1; bus.waddr = 8'h40; bus.wdata = mw(3'd7, 2'd0, 8'h41, 8'h00, 8'h07, 0, 0, 0);
        tick();
        bus.en = 1'b0; bus.we = 1'b0;
        check("coll_old",  {29'b0, bus.opc}, 32'd6);
        check("coll_oldb", {24'b0, bus.DIRB}, 32'h40);
        fetch(8'h40);
        check("coll_new",  {29'b0, bus.opc}, 32'd7);
        check("coll_newb", {24'b0, bus.DIRB}, 32'h41);

        // Asynchronous reset mid-run, checked away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("arst_opc",  {29'b0, bus.opc}, 32'd0);
        check("arst_dirb", {24'b0, bus.DIRB}, 32'd0);
        check("arst_ctrl", {24'b0, bus.ctrl}, 32'd0);
        check("arst_run",  {31'b0, bus.run}, 32'd0);
        #4 rst_n = 1'b1;
        tick();
        check("post_rst_run", {31'b0, bus.run}, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
